// File: rtl/tri_and3_response_checker.sv
// Response checker for a triple 3-input AND gate: accepts applied vectors, waits a
// settle time, compares observed Y1..Y3 to the ideal AND and keeps pass/fail stats.
module tri_and3_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_VECTORS   = 21,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [8:0]       vec_in,
  input  logic [2:0]       y_in,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [8:0]       first_fail_vec,
  output logic [2:0]       first_fail_y
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] NUM_V       = CNT_W'(NUM_VECTORS);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {IDLE, WAIT_VEC, SETTLE, COMPARE, DONE} state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [8:0]         vec_q, vec_d;
  logic [CNT_W-1:0]   vec_count_q, vec_count_d;
  logic [CNT_W-1:0]   pass_d, fail_d;
  logic [8:0]         ffv_d;
  logic [2:0]         ffy_d;
  logic               mismatch_d, vec_ready_d, busy_d, done_d, all_pass_d;
  logic [2:0]         exp_y;
  logic               y_ok;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      vec_q          <= '0;
      vec_count_q    <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vec <= '0;
      first_fail_y   <= '0;
      mismatch       <= 1'b0;
      vec_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      vec_q          <= vec_d;
      vec_count_q    <= vec_count_d;
      pass_cnt       <= pass_d;
      fail_cnt       <= fail_d;
      first_fail_vec <= ffv_d;
      first_fail_y   <= ffy_d;
      mismatch       <= mismatch_d;
      vec_ready      <= vec_ready_d;
      busy           <= busy_d;
      done           <= done_d;
      all_pass       <= all_pass_d;
    end
  end

  // Next state, counters and output decode; start restarts a run from any state
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    vec_d       = vec_q;
    vec_count_d = vec_count_q;
    pass_d      = pass_cnt;
    fail_d      = fail_cnt;
    ffv_d       = first_fail_vec;
    ffy_d       = first_fail_y;
    mismatch_d  = 1'b0;
    exp_y       = {&vec_q[8:6], &vec_q[5:3], &vec_q[2:0]};
    y_ok        = (y_in === exp_y);

    if (start) begin
      state_d     = WAIT_VEC;
      settle_d    = '0;
      vec_count_d = '0;
      pass_d      = '0;
      fail_d      = '0;
      ffv_d       = '0;
      ffy_d       = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT_VEC: begin
          if (vec_valid) begin
            vec_d    = vec_in;
            settle_d = SETTLE_LOAD;
            state_d  = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
          end
        end
        SETTLE: begin
          settle_d = settle_q - SET_W'(1);
          if (settle_q <= SET_W'(1)) state_d = COMPARE;
        end
        COMPARE: begin
          if (y_ok) begin
            if (pass_cnt != CNT_MAX) pass_d = pass_cnt + CNT_W'(1);
          end else begin
            if (fail_cnt != CNT_MAX) fail_d = fail_cnt + CNT_W'(1);
            mismatch_d = 1'b1;
            if (fail_cnt == '0) begin
              ffv_d = vec_q;
              ffy_d = y_in;
            end
          end
          vec_count_d = vec_count_q + CNT_W'(1);
          state_d     = (vec_count_d == NUM_V) ? DONE : WAIT_VEC;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    vec_ready_d = (state_d == WAIT_VEC);
    busy_d      = (state_d == WAIT_VEC) || (state_d == SETTLE) || (state_d == COMPARE);
    done_d      = (state_d == DONE);
    all_pass_d  = done_d && (fail_d == '0);
  end

endmodule

// File: tb/tb_tri_and3_response_checker.sv
// Directed bench for tri_and3_response_checker: a default instance and a small
// instance (CNT_W=2, NUM_VECTORS=3, SETTLE_CYCLES=0).
module tb_tri_and3_response_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, valid_a, ready_a, busy_a, done_a, allp_a, mm_a;
  logic [8:0] vin_a, ffv_a;
  logic [2:0] y_a, ffy_a;
  logic [7:0] pass_a, fail_a;

  logic       start_b, valid_b, ready_b, busy_b, done_b, allp_b, mm_b;
  logic [8:0] vin_b, ffv_b;
  logic [2:0] y_b, ffy_b;
  logic [1:0] pass_b, fail_b;

  int n_checks = 0;
  int n_errors = 0;

  tri_and3_response_checker dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_valid(valid_a), .vec_ready(ready_a),
    .vec_in(vin_a), .y_in(y_a), .busy(busy_a), .done(done_a), .all_pass(allp_a),
    .mismatch(mm_a), .pass_cnt(pass_a), .fail_cnt(fail_a),
    .first_fail_vec(ffv_a), .first_fail_y(ffy_a)
  );

  tri_and3_response_checker #(.SETTLE_CYCLES(0), .NUM_VECTORS(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_valid(valid_b), .vec_ready(ready_b),
    .vec_in(vin_b), .y_in(y_b), .busy(busy_b), .done(done_b), .all_pass(allp_b),
    .mismatch(mm_b), .pass_cnt(pass_b), .fail_cnt(fail_b),
    .first_fail_vec(ffv_b), .first_fail_y(ffy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ideal(input logic [8:0] v);
    return {&v[8:6], &v[5:3], &v[2:0]};
  endfunction

  function automatic logic [8:0] walk_vec(input int i);
    return {3'(i), 3'(i + 3), 3'(i + 5)};
  endfunction

  task automatic pulse_start(input bit use_b);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Waits for vec_ready, presents one vector for one accepting edge; returns #1 after that edge
  task automatic send(input bit use_b, input logic [8:0] v, input logic [2:0] y);
    int n;
    n = 0;
    while (!(use_b ? ready_b : ready_a) && n < 50) begin
      tick(1);
      n++;
    end
    if (!(use_b ? ready_b : ready_a)) begin
      check("ready_timeout", 32'(use_b ? ready_b : ready_a), 32'd1);
      return;
    end
    if (use_b) begin valid_b = 1'b1; vin_b = v; y_b = y; end
    else       begin valid_a = 1'b1; vin_a = v; y_a = y; end
    tick(1);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_done(input bit use_b, input string tag);
    int n;
    n = 0;
    while (!(use_b ? done_b : done_a) && n < 20) begin
      tick(1);
      n++;
    end
    check(tag, 32'(use_b ? done_b : done_a), 32'd1);
  endtask

  initial begin
    int busy_cycles, ready_cycles;
    rst_n = 1'b0;
    start_a = 0; valid_a = 0; vin_a = '0; y_a = '0;
    start_b = 0; valid_b = 0; vin_b = '0; y_b = '0;
    tick(2);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ready", 32'(ready_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_allpass", 32'(allp_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_ffv", 32'(ffv_a), 0);
    rst_n = 1'b1;
    tick(1);

    // 1: ideal gate, 21 walking vectors
    pulse_start(0);
    check("t1_busy", 32'(busy_a), 1);
    check("t1_ready", 32'(ready_a), 1);
    for (int i = 0; i < 21; i++) send(0, walk_vec(i), ideal(walk_vec(i)));
    wait_done(0, "t1_done");
    check("t1_pass", 32'(pass_a), 21);
    check("t1_fail", 32'(fail_a), 0);
    check("t1_allpass", 32'(allp_a), 1);
    check("t1_busy_end", 32'(busy_a), 0);

    // 2: Y2 stuck at 0; expected response to 9'h038 is 3'b010
    pulse_start(0);
    send(0, 9'h038, 3'b000);
    tick(2);
    check("t2_no_early_mm", 32'(mm_a), 0);
    tick(1);
    check("t2_mm", 32'(mm_a), 1);
    check("t2_fail", 32'(fail_a), 1);
    check("t2_ffv", 32'(ffv_a), 32'h038);
    check("t2_ffy", 32'(ffy_a), 0);
    tick(1);
    check("t2_mm_pulse", 32'(mm_a), 0);
    send(0, 9'h1c0, 3'b000);
    for (int i = 2; i < 21; i++) send(0, walk_vec(i), ideal(walk_vec(i)));
    wait_done(0, "t2_done");
    check("t2_fail2", 32'(fail_a), 2);
    check("t2_pass", 32'(pass_a), 19);
    check("t2_ffv_kept", 32'(ffv_a), 32'h038);
    check("t2_allpass", 32'(allp_a), 0);

    // 3: settle window, y_in correct just in time then one cycle late
    pulse_start(0);
    send(0, 9'h1ff, 3'b000);
    tick(2);
    y_a = 3'b111;
    tick(1);
    check("t3_ontime_pass", 32'(pass_a), 1);
    check("t3_ontime_fail", 32'(fail_a), 0);
    send(0, 9'h1ff, 3'b000);
    tick(3);
    y_a = 3'b111;
    check("t3_late_fail", 32'(fail_a), 1);
    check("t3_late_mm", 32'(mm_a), 1);
    check("t3_late_ffy", 32'(ffy_a), 0);

    // 4: abort mid-run, then vec_valid held high for the whole run
    pulse_start(0);
    check("t4_abort_fail", 32'(fail_a), 0);
    check("t4_abort_pass", 32'(pass_a), 0);
    check("t4_abort_ffv", 32'(ffv_a), 0);
    valid_a = 1'b1; vin_a = 9'h1ff; y_a = 3'b111;
    busy_cycles = 0;
    ready_cycles = 0;
    for (int n = 0; n < 200 && busy_a; n++) begin
      busy_cycles++;
      if (ready_a) ready_cycles++;
      tick(1);
    end
    check("t4_busy_cycles", 32'(busy_cycles), 84);
    check("t4_ready_cycles", 32'(ready_cycles), 21);
    tick(3);
    check("t4_pass", 32'(pass_a), 21);
    check("t4_done_hold", 32'(done_a), 1);
    check("t4_ready_done", 32'(ready_a), 0);
    valid_a = 1'b0;

    // 5: reset during SETTLE of vector 7
    pulse_start(0);
    for (int i = 0; i < 6; i++) send(0, walk_vec(i), ideal(walk_vec(i)));
    send(0, walk_vec(6), ideal(walk_vec(6)));
    check("t5_pre_pass", 32'(pass_a), 6);
    rst_n = 1'b0;
    tick(1);
    check("t5_rst_pass", 32'(pass_a), 0);
    check("t5_rst_busy", 32'(busy_a), 0);
    check("t5_rst_ready", 32'(ready_a), 0);
    check("t5_rst_done", 32'(done_a), 0);
    rst_n = 1'b1;
    tick(1);
    check("t5_idle_ready", 32'(ready_a), 0);
    pulse_start(0);
    for (int i = 0; i < 21; i++) send(0, walk_vec(i), ideal(walk_vec(i)));
    wait_done(0, "t5_done");
    check("t5_pass", 32'(pass_a), 21);

    // 6: small instance, every response wrong; then restart after 2 vectors
    pulse_start(1);
    for (int i = 0; i < 3; i++) send(1, 9'h1ff, 3'b000);
    wait_done(1, "t6_done");
    check("t6_fail_max", 32'(fail_b), 3);
    check("t6_pass", 32'(pass_b), 0);
    check("t6_allpass", 32'(allp_b), 0);
    check("t6_ffv", 32'(ffv_b), 32'h1ff);
    pulse_start(1);
    check("t6_clear", 32'(fail_b), 0);
    send(1, 9'h1ff, 3'b111);
    send(1, 9'h1c0, 3'b100);
    pulse_start(1);
    check("t6_restart_pass", 32'(pass_b), 0);
    send(1, 9'h007, 3'b001);
    send(1, 9'h000, 3'b000);
    tick(2);
    check("t6_not_done", 32'(done_b), 0);
    send(1, 9'h038, 3'b010);
    wait_done(1, "t6_done2");
    check("t6_pass3", 32'(pass_b), 3);
    check("t6_allpass2", 32'(allp_b), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
